// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-button synchroniser, debouncer and change/on_off arbiter; auto-repeat built only with BUTTON_AUTO_REPEAT_EN
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic change,
  output logic on_off,
  output logic locked
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("button_conditioner: parameter out of range");
  end

  // Bit 0 carries the up button, bit 1 the down button, through sync and debounce.
  logic [1:0]          raw_meta_q;
  logic [1:0]          raw_sync_q;
  logic [1:0]          deb_q;
  logic [1:0]          deb_d;
  logic [1:0][DCW-1:0] cnt_q;
  logic [1:0][DCW-1:0] cnt_d;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LOCKOUT = 2'd2, S_REPEAT = 2'd3} state_t;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_LOCKOUT = 2'd2} state_t;
`endif

  state_t state_q;
  state_t state_d;
  logic   change_q, change_d;
  logic   on_off_q, on_off_d;
  logic   locked_q, locked_d;
  logic   deb_up, deb_dn, active, opposite;

  // Two-flop synchronisers: the only logic that touches the raw pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_meta_q <= '0;
      raw_sync_q <= '0;
    end else begin
      raw_meta_q <= {btn_down, btn_up};
      raw_sync_q <= raw_meta_q;
    end
  end

  // Debounce: accept a new level once it has differed from deb for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (raw_sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_up   = deb_q[0];
  assign deb_dn   = deb_q[1];
  // The direction of the last pulse identifies which button the hold belongs to.
  assign active   = on_off_q ? deb_up : deb_dn;
  assign opposite = on_off_q ? deb_dn : deb_up;

  // Arbitration next state; release beats opposite-press, which beats a repeat pulse.
  always_comb begin
    state_d  = state_q;
    change_d = 1'b0;
    on_off_d = on_off_q;
    case (state_q)
      S_IDLE: begin
        if (deb_up && deb_dn) begin
          state_d = S_LOCKOUT;
        end else if (deb_up) begin
          change_d = 1'b1;
          on_off_d = 1'b1;
          state_d  = S_HELD;
        end else if (deb_dn) begin
          change_d = 1'b1;
          on_off_d = 1'b0;
          state_d  = S_HELD;
        end
      end
      S_HELD: begin
        if (!active) begin
          state_d = S_IDLE;
        end else if (opposite) begin
          state_d = S_LOCKOUT;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
          change_d = 1'b1;
          state_d  = S_REPEAT;
        end
`endif
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      S_REPEAT: begin
        if (!active) begin
          state_d = S_IDLE;
        end else if (opposite) begin
          state_d = S_LOCKOUT;
        end else if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
          change_d = 1'b1;
        end
      end
`endif
      S_LOCKOUT: begin
        if (!deb_up && !deb_dn) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    locked_d = (state_d == S_LOCKOUT);
`ifdef BUTTON_AUTO_REPEAT_EN
    // Timer restarts on any state entry and on every pulse, otherwise free-runs.
    timer_d = ((state_d != state_q) || change_d) ? '0 : timer_q + TW'(1);
`endif
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      timer_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
      on_off_q <= on_off_d;
      locked_q <= locked_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      timer_q  <= timer_d;
`endif
    end
  end

  assign change = change_q;
  assign on_off = on_off_q;
  assign locked = locked_q;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input stage that feeds the up/down event counter (`monitor`). It turns two raw, bouncing, asynchronous push-buttons (up, down) into that counter's `change`/`on_off` command pair. It synchronises and debounces each button and arbitrates simultaneous presses. It emits exactly one single-cycle `change` pulse per accepted press, with optional auto-repeat while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a new level must persist before it is accepted (≥1).
- `REPEAT_DELAY`, default 16: cycles from the initial pulse to the first auto-repeat pulse (≥2).
- `REPEAT_PERIOD`, default 4: cycles between subsequent auto-repeat pulses (≥2).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserting it clears all state immediately.
- `btn_up`  in  1  raw up button, asynchronous, active-high.
- `btn_down`  in  1  raw down button, asynchronous, active-high.
- `change`  out  1  registered single-cycle command pulse.
- `on_off`  out  1  registered direction: 1 = increment, 0 = decrement; valid whenever `change`=1 and held between pulses.
- `locked`  out  1  registered; high while both buttons are accepted as pressed (lockout state).

## Operation
- Synchroniser: each raw input passes through a 2-flop synchroniser. No other logic samples the raw pins.
- Debounce, per button:
  - Keep a stable level `deb` and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Synchronised value ≠ `deb`: counter increments. Equal: counter clears.
  - Counter reaching DEBOUNCE_CYCLES: `deb` flips and counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES causes no change in `deb`.
- Arbitration FSM, states IDLE, HELD, REPEAT, LOCKOUT; reset state IDLE.
  - IDLE:
    - `deb_up`&!`deb_dn`: pulse `change`, set `on_off`=1, go to HELD.
    - `deb_dn`&!`deb_up`: pulse `change`, set `on_off`=0, go to HELD.
    - Both high in the same cycle: no pulse, go to LOCKOUT.
  - HELD: repeat timer increments each cycle.
    - Active button released: go to IDLE.
    - Opposite button becomes accepted: go to LOCKOUT, no pulse.
    - Timer = REPEAT_DELAY−1 (auto-repeat only): pulse, clear timer, go to REPEAT.
  - REPEAT:
    - Timer = REPEAT_PERIOD−1: pulse and clear timer.
    - Release and opposite-press transitions are the same as in HELD.
  - LOCKOUT: `locked`=1. Exit to IDLE only when both `deb` levels are 0.
- Release and opposite-press take priority over a repeat pulse in the same cycle.
- `on_off` updates only when a pulse is issued and otherwise holds its value.
- Repeat timer width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)). The timer clears on every state entry.

## Timing
- Reset values: `change`=0, `on_off`=0, `locked`=0, FSM=IDLE, all `deb`, counters and synchroniser flops = 0.
- Press latency: a raw level first sampled high at edge N, held clean, produces `change`=1 in the cycle after edge N+DEBOUNCE_CYCLES+2 (default: 7 edges).
- Release latency: the same DEBOUNCE_CYCLES+2 edges before the FSM sees the release.
- `change` is never high for two consecutive cycles.
- Minimum spacing between pulses is REPEAT_PERIOD cycles.
- Reset asserted mid-pulse or mid-hold: outputs clear asynchronously. After release, a still-held button requires a fresh full debounce and produces a new initial pulse.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined: HELD→REPEAT transition and periodic pulses are present as described.
- Not defined: the HELD state is permanent until release or opposite press, with exactly one pulse per accepted press. The repeat timer and the REPEAT state are not built. `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.

## Test plan
- Reset: hold `rst`=0, toggle buttons → `change`=0, `on_off`=0, `locked`=0 throughout. Release reset with buttons low → still idle.
- Clean up press, defaults: `btn_up`=1 for 10 cycles → exactly one `change` pulse, 7 edges after first sample, with `on_off`=1. No auto-repeat, since release precedes REPEAT_DELAY.
- Bounce rejection: `btn_down` toggled 1,0,1,0 each held 2 cycles, then steady 1 → no pulse during the bounce. One pulse with `on_off`=0 occurs DEBOUNCE_CYCLES+2 edges after the steady level begins.
- Auto-repeat (macro on): `btn_up` held 40 cycles after acceptance → pulses at relative cycles 0, 16, 20, 24, 28, 32, 36, all with `on_off`=1. With the macro off, only the pulse at 0.
- Simultaneous press: both buttons rise together → no pulse and `locked`=1. Release `btn_up` only → `locked` stays 1. Release both → `locked`=0 and FSM in IDLE.
- Reset mid-repeat: assert `rst` during REPEAT with `btn_up` held → `change`=0 immediately. After release, the first pulse comes 7 edges later.
